// File: rtl/sr_pkg.sv
// Shared encodings for the SR latch controller: FSM state codes and op values.
package sr_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SETUP = 3'd1;
  localparam logic [2:0] ST_PULSE = 3'd2;
  localparam logic [2:0] ST_HOLD  = 3'd3;
  localparam logic [2:0] ST_SYNC  = 3'd4;
  localparam logic [2:0] ST_CHECK = 3'd5;
  localparam logic [2:0] ST_GUARD = 3'd6;

  localparam logic OP_SET   = 1'b1;
  localparam logic OP_RESET = 1'b0;

  // Cycles spent in SYNC; matches the depth of the Q synchronizer.
  localparam int SYNC_CYC = 2;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer bringing the asynchronous latch outputs into the clk domain.
module sync2 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/sr_latch_ctrl.sv
// Sequencer for a bank of gated SR latches: arbitrates two requesters, pulses one
// cell at a time with setup/hold around En, then verifies the cell through a synchronizer.
module sr_latch_ctrl
  import sr_pkg::*;
#(
  parameter int  N_LATCH   = 8,
  parameter int  PULSE_CYC = 2,
  parameter int  GUARD_CYC = 1,
  localparam int IW        = $clog2(N_LATCH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               a_valid,
  output logic               a_ready,
  input  logic [IW-1:0]      a_idx,
  input  logic               a_op,
  input  logic               b_valid,
  output logic               b_ready,
  input  logic [IW-1:0]      b_idx,
  input  logic               b_op,
  output logic [N_LATCH-1:0] S,
  output logic [N_LATCH-1:0] R,
  output logic [N_LATCH-1:0] En,
  input  logic [N_LATCH-1:0] Q,
  output logic               busy,
  output logic               done,
  output logic               err
);

  localparam logic [IW:0] IDX_LIMIT = (IW+1)'(N_LATCH);
  localparam logic [3:0]  PULSE_LD  = 4'(PULSE_CYC - 1);
  localparam logic [3:0]  GUARD_LD  = 4'(GUARD_CYC - 1);
  localparam logic [3:0]  SYNC_LD   = 4'(SYNC_CYC - 1);

  logic [2:0]         r_state;
  logic [3:0]         r_cnt;
  logic               r_prio_b;
  logic               r_bad;
  logic [IW-1:0]      r_idx;
  logic               r_op;

  logic               w_idle;
  logic               w_grant_a;
  logic               w_grant_b;
  logic               w_accept;
  logic [IW-1:0]      w_req_idx;
  logic               w_req_op;
  logic               w_req_ok;
  logic [N_LATCH-1:0] w_sel;
  logic [N_LATCH-1:0] w_q_sync;
  logic               w_q_bit;
  logic               w_drive_sr;
  logic               w_check;

  sync2 #(.WIDTH(N_LATCH)) u_sync2 (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (Q),
    .o_q   (w_q_sync)
  );

  // Round-robin: r_prio_b is set after A wins so B takes the next tie.
  assign w_idle    = (r_state == ST_IDLE);
  assign w_grant_a = w_idle & a_valid & (~b_valid | ~r_prio_b);
  assign w_grant_b = w_idle & b_valid & (~a_valid | r_prio_b);
  assign w_accept  = w_grant_a | w_grant_b;
  assign a_ready   = w_grant_a;
  assign b_ready   = w_grant_b;
  assign w_req_idx = w_grant_b ? b_idx : a_idx;
  assign w_req_op  = w_grant_b ? b_op : a_op;
  assign w_req_ok  = ({1'b0, w_req_idx} < IDX_LIMIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_prio_b <= 1'b0;
      r_bad    <= 1'b0;
    end else begin
      r_bad <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_prio_b <= w_grant_a;
            if (w_req_ok) begin
              r_state <= ST_SETUP;
            end else begin
              r_state <= ST_GUARD;
              r_cnt   <= GUARD_LD;
              r_bad   <= 1'b1;
            end
          end
        end
        ST_SETUP: begin
          r_state <= ST_PULSE;
          r_cnt   <= PULSE_LD;
        end
        ST_PULSE: begin
          if (r_cnt == '0) r_state <= ST_HOLD;
          else             r_cnt   <= r_cnt - 4'd1;
        end
        ST_HOLD: begin
          r_state <= ST_SYNC;
          r_cnt   <= SYNC_LD;
        end
        ST_SYNC: begin
          if (r_cnt == '0) r_state <= ST_CHECK;
          else             r_cnt   <= r_cnt - 4'd1;
        end
        ST_CHECK: begin
          r_state <= ST_GUARD;
          r_cnt   <= GUARD_LD;
        end
        ST_GUARD: begin
          if (r_cnt == '0) r_state <= ST_IDLE;
          else             r_cnt   <= r_cnt - 4'd1;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_idx <= w_req_idx;
      r_op  <= w_req_op;
    end
  end

  always_comb begin
    w_sel = '0;
    for (int i = 0; i < N_LATCH; i++) w_sel[i] = (r_idx == IW'(i));
  end

  // Bad indices never reach SETUP/PULSE/HOLD, so w_sel is only used for legal cells.
  assign w_drive_sr = (r_state == ST_SETUP) | (r_state == ST_PULSE) | (r_state == ST_HOLD);
  assign w_check    = (r_state == ST_CHECK);
  assign w_q_bit    = |(w_q_sync & w_sel);

  assign S    = (w_drive_sr && r_op == OP_SET)   ? w_sel : '0;
  assign R    = (w_drive_sr && r_op == OP_RESET) ? w_sel : '0;
  assign En   = (r_state == ST_PULSE)            ? w_sel : '0;
  assign busy = ~w_idle;
  assign done = w_check & (w_q_bit == r_op);
  assign err  = r_bad | (w_check & (w_q_bit != r_op));

endmodule

// File: doc/sr_latch_ctrl.md
SR_LATCH_CTRL -- requirements
Module: sr_latch_ctrl

Interface
REQ-001 SHALL have parameter N_LATCH, default 8, giving the number of gated SR latch cells driven (2..32).
REQ-002 SHALL have parameter PULSE_CYC, default 2, giving the En-high cycles per write (1..15).
REQ-003 SHALL have parameter GUARD_CYC, default 1, giving the all-inactive cycles after each operation (1..15).
REQ-004 SHALL have one clock and an asynchronous, active-low reset, named as follows:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
REQ-005 SHALL have these requester ports (IW = clog2(N_LATCH)):
- a_valid  in  1  requester A operation pending.
- a_ready  out  1  requester A accepted this cycle.
- a_idx  in  IW  target latch for A.
- a_op  in  1  op for A: 1 = set, 0 = reset.
- b_valid  in  1  requester B operation pending.
- b_ready  out  1  requester B accepted this cycle.
- b_idx  in  IW  target latch for B.
- b_op  in  1  op for B: 1 = set, 0 = reset.
REQ-006 SHALL have these latch-bank and status ports:
- S  out  N_LATCH  per-cell set input.
- R  out  N_LATCH  per-cell reset input.
- En  out  N_LATCH  per-cell enable.
- Q  in  N_LATCH  per-cell latch output, asynchronous to clk.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse: operation verified.
- err  out  1  one-cycle pulse: readback mismatch or bad index.

Function
REQ-007 SHALL implement FSM states IDLE, SETUP, PULSE, HOLD, SYNC, CHECK and GUARD.
REQ-008 SHALL, in IDLE, grant exactly one valid requester with ready=1 combinationally; the handshake is valid&ready.
REQ-009 SHALL arbitrate round-robin: when both are valid, grant the requester not granted last; after reset, A has priority.
REQ-010 SHALL, on acceptance, register idx and op and move to SETUP; if idx >= N_LATCH it SHALL instead pulse err the next cycle and enter GUARD, driving no S/R/En.
REQ-011 SETUP (1 cycle) SHALL drive S[idx]=op and R[idx]=~op with En low.
REQ-012 PULSE (PULSE_CYC cycles) SHALL additionally drive En[idx]=1.
REQ-013 HOLD (1 cycle) SHALL drop En while keeping S/R, giving data hold around the En edges.
REQ-014 SYNC (2 cycles) SHALL drive S/R/En all zero while Q passes a 2-flop synchronizer.
REQ-015 CHECK (1 cycle) SHALL compare synchronized Q[idx] with op; on match done=1, otherwise err=1; the FSM then moves to GUARD.
REQ-016 GUARD (GUARD_CYC cycles) SHALL drive all outputs inactive, then return to IDLE.
REQ-017 SHALL never assert S[i] and R[i] together, and SHALL never drive more than one index at a time.
REQ-018 SHALL give latency from acceptance at cycle T with defaults as follows:
- done/err at T+7.
- next possible ready at T+9.
REQ-019 SHALL keep ready low in every state except IDLE; requests arriving while busy wait, and they are not queued internally.
REQ-020 SHALL handle simultaneous A/B requests to the same idx with opposite ops by serializing them in round-robin order; the final latch value equals the second op.

Reset
REQ-021 SHALL, while rst_n=0 (asynchronously, including mid-PULSE), force the following:
- FSM to IDLE.
- S, R, En, done, err, busy and the synchronizer flops to 0.
- Round-robin pointer to favour A.
REQ-022 SHALL leave latch contents untouched by reset; no implicit clear pulse is issued.

Structure
REQ-023 SHALL place the FSM state enumeration and the op encoding constants (OP_SET=1, OP_RESET=0) in a shared package, sr_pkg.
REQ-024 SHALL implement the Q synchronizer as one sub-module, sync2, N_LATCH wide, clocked by clk and reset by rst_n.

Verification
REQ-025 The bench SHALL cover a single set: A req idx=3 op=1 at T -> S[3]=1 at T+1..T+4, En[3]=1 at T+2..T+3, done at T+7, model Q[3]=1.
REQ-026 The bench SHALL cover a contention case: A(idx 5, set) and B(idx 5, reset) valid in the same cycle -> A granted first; B granted at T+9; final Q[5]=0; two done pulses.
REQ-027 The bench SHALL cover a bad index: N_LATCH=6, B req idx=7 -> b_ready=1, err at T+1, no S/R/En activity, IDLE at T+2.
REQ-028 The bench SHALL cover a readback fault: model holds Q[2] stuck at 0, A req idx=2 set -> err at T+7, no done.
REQ-029 The bench SHALL cover reset mid-operation: rst_n low during PULSE -> En/S/R zero within the same cycle; after release, ready=1 for A first.
REQ-030 The bench SHALL check the safety property on every cycle: (S&R)==0 and popcount(S|R|En) <= 1.
